// File: rtl/cpu_pipe_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pipe_pkg
// Shared definitions for the pipelined CPU inter-stage registers:
//   - pipe_state_e : occupancy state of a pipe_stage_reg (encoding == count)
//   - per-boundary control/data bundle widths
//   - control bit indices and data field offsets used when packing bundles
//   - small field extraction helpers for the EX/MEM bundle
// -----------------------------------------------------------------------------
package cpu_pipe_pkg;

    // Encoding equals the number of held entries, so occupancy is the state.
    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_e;

    // Control bundle bit indices (common to every boundary that carries them).
    localparam int CTRL_REG_WRITE = 0;
    localparam int CTRL_MEM_READ  = 1;
    localparam int CTRL_MEM_WRITE = 2;
    localparam int CTRL_MEM_REG   = 3;
    localparam int CTRL_BRANCH    = 4;
    localparam int CTRL_JUMP      = 5;

    // IF/ID: pc + instruction word, single "valid instruction" control bit.
    localparam int IFID_CTRL_W     = 1;
    localparam int IFID_PC_LSB     = 0;
    localparam int IFID_INSTR_LSB  = 64;
    localparam int IFID_DATA_W     = 96;

    // EX/MEM: pc, alu result, store data, rd, func3, zero flag, branch taken.
    localparam int EXMEM_CTRL_W    = 8;
    localparam int EXMEM_PC_LSB    = 0;
    localparam int EXMEM_ALU_LSB   = 64;
    localparam int EXMEM_STORE_LSB = 128;
    localparam int EXMEM_RD_LSB    = 192;
    localparam int EXMEM_FUNC3_LSB = 197;
    localparam int EXMEM_ZERO_LSB  = 200;
    localparam int EXMEM_TAKEN_LSB = 201;
    localparam int EXMEM_DATA_W    = 202;

    // MEM/WB: pc, write-back value, rd.
    localparam int MEMWB_CTRL_W    = 8;
    localparam int MEMWB_PC_LSB    = 0;
    localparam int MEMWB_RESULT_LSB = 64;
    localparam int MEMWB_RD_LSB    = 128;
    localparam int MEMWB_DATA_W    = 133;

    function automatic logic [63:0] exmem_alu_result(input logic [EXMEM_DATA_W-1:0] d);
        return d[EXMEM_ALU_LSB +: 64];
    endfunction

    function automatic logic [4:0] exmem_rd(input logic [EXMEM_DATA_W-1:0] d);
        return d[EXMEM_RD_LSB +: 5];
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_if
// Signal bundle of one stage boundary.
//   flush                         : synchronous kill of the held entries
//   in_valid/in_ready/in_ctrl/in_data     : upstream handshake and bundles
//   out_valid/out_ready/out_ctrl/out_data : downstream handshake and bundles
//   occupancy                     : number of held entries (0..2)
// Modports:
//   slave  : the stage register itself
//   master : the surrounding pipeline (upstream driver + downstream consumer)
// -----------------------------------------------------------------------------
interface pipe_stage_reg_if #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 202
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    modport slave (
        input  flush, in_valid, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_data, occupancy
    );

    modport master (
        output flush, in_valid, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data, occupancy
    );
endinterface

// File: rtl/pipe_entry_reg.sv
// -----------------------------------------------------------------------------
// pipe_entry_reg
// One pipeline entry: control and data bundle registers.
//   clk, reset : clock, asynchronous active-high reset (clears both bundles)
//   load       : capture d_ctrl/d_data
//   clr_ctrl   : clear the control bundle (wins over load); data is untouched
//   d_ctrl/d_data -> q_ctrl/q_data
// -----------------------------------------------------------------------------
module pipe_entry_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 202
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clr_ctrl,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; this is what lets main load from skid while skid clears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_ctrl <= '0;
            // NOTE: the wide data register is reset too, because the
            // downstream stage observes out_data=0 straight out of reset.
            q_data <= '0;
        end else begin
            if (clr_ctrl)
                q_ctrl <= '0;
            else if (load)
                q_ctrl <= d_ctrl;

            if (load)
                q_data <= d_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Elastic valid/ready stage register between two CPU pipeline stages.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : pipe_stage_reg_if.slave (flush, in_*, out_*, occupancy)
// Parameters:
//   CTRL_W, DATA_W : bundle widths (must match the interface instance)
//   SKID           : 1 = main + skid entry, in_ready from state only
//                    0 = single entry, in_ready = !out_valid || out_ready
// The main entry drives out_*; out_ctrl is kept zero whenever the main entry
// is empty so a bubble can never carry a live control bit downstream.
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int CTRL_W = EXMEM_CTRL_W,
    parameter int DATA_W = EXMEM_DATA_W,
    parameter bit SKID   = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    pipe_stage_reg_if.slave bus
);

    pipe_state_e       state, state_nxt;
    logic              push, pop;
    logic              main_load, main_from_skid, main_clr;
    logic              skid_load, skid_clr;
    logic [CTRL_W-1:0] main_d_ctrl, main_q_ctrl, skid_q_ctrl;
    logic [DATA_W-1:0] main_d_data, main_q_data, skid_q_data;

    assign bus.out_valid = (state != PS_EMPTY);
    assign bus.out_ctrl  = main_q_ctrl;
    assign bus.out_data  = main_q_data;
    assign bus.occupancy = state;

    generate
        if (SKID) begin : g_ready_reg
            // Registered ready: backpressure never ripples combinationally upstream.
            assign bus.in_ready = (state != PS_FULL);
        end else begin : g_ready_comb
            assign bus.in_ready = !bus.out_valid || bus.out_ready;
        end
    endgenerate

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= PS_EMPTY;
        else
            state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt      = state;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        main_clr       = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;

        if (bus.flush) begin
            // Kill everything; any push or pop this cycle is discarded.
            state_nxt = PS_EMPTY;
            main_clr  = 1'b1;
            skid_clr  = 1'b1;
        end else begin
            unique case (state)
                PS_EMPTY: begin
                    if (push) begin
                        main_load = 1'b1;
                        state_nxt = PS_ONE;
                    end
                end
                PS_ONE: begin
                    if (push && pop) begin
                        main_load = 1'b1;
                    end else if (push) begin
                        // Only reachable with SKID=1: ready is registered, so
                        // the entry accepted under backpressure parks in skid.
                        skid_load = 1'b1;
                        state_nxt = PS_FULL;
                    end else if (pop) begin
                        main_clr  = 1'b1;
                        state_nxt = PS_EMPTY;
                    end
                end
                PS_FULL: begin
                    if (pop) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                        state_nxt      = PS_ONE;
                    end
                end
                default: state_nxt = PS_EMPTY;
            endcase
        end
    end

    assign main_d_ctrl = main_from_skid ? skid_q_ctrl : bus.in_ctrl;
    assign main_d_data = main_from_skid ? skid_q_data : bus.in_data;

    pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk      (clk),
        .reset    (reset),
        .load     (main_load),
        .clr_ctrl (main_clr),
        .d_ctrl   (main_d_ctrl),
        .d_data   (main_d_data),
        .q_ctrl   (main_q_ctrl),
        .q_data   (main_q_data)
    );

    generate
        if (SKID) begin : g_skid
            pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
                .clk      (clk),
                .reset    (reset),
                .load     (skid_load),
                .clr_ctrl (skid_clr),
                .d_ctrl   (bus.in_ctrl),
                .d_data   (bus.in_data),
                .q_ctrl   (skid_q_ctrl),
                .q_data   (skid_q_data)
            );
        end else begin : g_no_skid
            assign skid_q_ctrl = '0;
            assign skid_q_data = '0;
        end
    endgenerate

endmodule
